// File: rtl/alu_test_sequencer.sv
// Exhaustive sweep tester for a 4-bit ALU: drives all 1024 {op, a, b} vectors, waits a
// configurable settle time, checks the result against a built-in model and tallies pass/fail.
module alu_test_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        cin_cfg,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic [2:0]  alu_f,
    output logic        alu_cin,
    input  logic [3:0]  alu_z,
    input  logic        alu_cout_add,
    input  logic        alu_cout_sub,
    input  logic        alu_ovf_add,
    input  logic        alu_ovf_sub,
    output logic        busy,
    output logic        done,
    output logic [10:0] pass_count,
    output logic [10:0] fail_count,
    output logic        first_fail_valid,
    output logic [9:0]  first_fail_vec
);

    typedef enum logic [2:0] {StIdle, StDrive, StSettle, StCheck, StDone} state_e;

    state_e      state_q, state_d;
    logic [9:0]  idx_q;
    logic [3:0]  settle_cnt_q;
    logic        cin_q;
    logic        last_vec;
    logic        settle_last;
    logic        mismatch;
    logic [4:0]  sum;
    logic [4:0]  diff;
    logic        ovf_add;
    logic        ovf_sub;

    assign last_vec    = &idx_q;
    assign settle_last = (settle_cnt_q == 4'(SETTLE_CYCLES - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StDrive;
            StDrive:  state_d = StSettle;
            StSettle: if (settle_last) state_d = StCheck;
            StCheck:  state_d = last_vec ? StDone : StDrive;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Moore outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            StDrive, StSettle, StCheck: busy = 1'b1;
            StDone:                     done = 1'b1;
            default:                    ;
        endcase
    end

    // Reference model evaluated on the operands currently driven to the ALU
    always_comb begin
        sum     = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
        diff    = {1'b0, alu_a} - {1'b0, alu_b} - {4'b0, alu_cin};
        ovf_add = (alu_a[3] == alu_b[3]) && (sum[3] != alu_a[3]);
        ovf_sub = (alu_a[3] != alu_b[3]) && (diff[3] != alu_a[3]);
        mismatch = 1'b0;
        // 4-state compare so an unknown on any checked bit is a mismatch
        case (alu_f[1:0])
            2'b00: mismatch = (alu_z !== sum[3:0]) || (alu_cout_add !== sum[4]) ||
                              (alu_ovf_add !== ovf_add);
            2'b01: mismatch = (alu_z !== diff[3:0]) || (alu_cout_sub !== ~diff[4]) ||
                              (alu_ovf_sub !== ovf_sub);
            2'b10: mismatch = (alu_z !== (alu_a & alu_b));
            default: mismatch = (alu_z !== (alu_a | alu_b));
        endcase
    end

    // Datapath: vector drive, settle timer, scoreboard counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q            <= '0;
            settle_cnt_q     <= '0;
            cin_q            <= 1'b0;
            alu_a            <= '0;
            alu_b            <= '0;
            alu_f            <= 3'b111;
            alu_cin          <= 1'b0;
            pass_count       <= '0;
            fail_count       <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        idx_q            <= '0;
                        cin_q            <= cin_cfg;
                        pass_count       <= '0;
                        fail_count       <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= '0;
                    end
                end
                StDrive: begin
                    alu_f        <= {1'b0, idx_q[9:8]};
                    alu_a        <= idx_q[7:4];
                    alu_b        <= idx_q[3:0];
                    alu_cin      <= cin_q;
                    settle_cnt_q <= '0;
                end
                StSettle: begin
                    settle_cnt_q <= settle_cnt_q + 4'd1;
                end
                StCheck: begin
                    if (mismatch) begin
                        fail_count <= fail_count + 11'd1;
                        if (!first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_vec   <= idx_q;
                        end
                    end else begin
                        pass_count <= pass_count + 11'd1;
                    end
                    idx_q <= idx_q + 10'd1;
                    if (last_vec) begin
                        alu_a   <= '0;
                        alu_b   <= '0;
                        alu_f   <= 3'b111;
                        alu_cin <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_test_sequencer.sv
// Bench for alu_test_sequencer: two instances (settle 1 and 3) driving a behavioural ALU with
// injectable faults; expected tallies come from a 1024-vector arithmetic model.
module tb_alu_test_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic cin_cfg = 1'b0;
    logic sel = 1'b0;
    int   fk = 0;
    int   fop = 0;
    int   fbit = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    logic [3:0]  a1, b1, z1, a3, b3, z3;
    logic [2:0]  f1, f3;
    logic        cin1, ca1, cs1, oa1, os1, busy1, done1, ffv1;
    logic        cin3, ca3, cs3, oa3, os3, busy3, done3, ffv3;
    logic [10:0] pc1, fc1, pc3, fc3;
    logic [9:0]  ffvec1, ffvec3;
    logic        start1, start3;

    // Fault kinds: 0 none, 1/2 z[fbit] stuck 0/1 on op fop, 3/4 flag fbit stuck 0/1
    function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [2:0] f, input logic cin,
                                             input int k, input int op, input int bt);
        int sa, sb, s, d;
        logic [3:0] z;
        logic [3:0] fl;
        sa = (a >= 8) ? int'(a) - 16 : int'(a);
        sb = (b >= 8) ? int'(b) - 16 : int'(b);
        s  = int'(a) + int'(b) + int'(cin);
        d  = int'(a) - int'(b) - int'(cin);
        fl[3] = (s >= 16);
        fl[2] = (int'(a) >= int'(b) + int'(cin));
        fl[1] = (sa + sb + int'(cin) > 7) || (sa + sb + int'(cin) < -8);
        fl[0] = (sa - sb - int'(cin) > 7) || (sa - sb - int'(cin) < -8);
        case (f)
            3'd0:    z = 4'(s & 15);
            3'd1:    z = 4'(d & 15);
            3'd2:    z = a & b;
            3'd3:    z = a | b;
            default: z = 4'd0;
        endcase
        if (int'(f) == op && k == 1) z[bt] = 1'b0;
        if (int'(f) == op && k == 2) z[bt] = 1'b1;
        if (k == 3) fl[3-bt] = 1'b0;
        if (k == 4) fl[3-bt] = 1'b1;
        return {z, fl};
    endfunction

    always_comb {z1, ca1, cs1, oa1, os1} = alu_model(a1, b1, f1, cin1, fk, fop, fbit);
    always_comb {z3, ca3, cs3, oa3, os3} = alu_model(a3, b3, f3, cin3, fk, fop, fbit);

    assign start1 = start & ~sel;
    assign start3 = start & sel;

    alu_test_sequencer #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .cin_cfg(cin_cfg),
        .alu_a(a1), .alu_b(b1), .alu_f(f1), .alu_cin(cin1), .alu_z(z1),
        .alu_cout_add(ca1), .alu_cout_sub(cs1), .alu_ovf_add(oa1), .alu_ovf_sub(os1),
        .busy(busy1), .done(done1), .pass_count(pc1), .fail_count(fc1),
        .first_fail_valid(ffv1), .first_fail_vec(ffvec1)
    );

    alu_test_sequencer #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .cin_cfg(cin_cfg),
        .alu_a(a3), .alu_b(b3), .alu_f(f3), .alu_cin(cin3), .alu_z(z3),
        .alu_cout_add(ca3), .alu_cout_sub(cs3), .alu_ovf_add(oa3), .alu_ovf_sub(os3),
        .busy(busy3), .done(done3), .pass_count(pc3), .fail_count(fc3),
        .first_fail_valid(ffv3), .first_fail_vec(ffvec3)
    );

    logic [3:0]  a_m, b_m;
    logic [2:0]  f_m;
    logic        cin_m, busy_m, done_m, ffv_m;
    logic [10:0] pc_m, fc_m;
    logic [9:0]  ffvec_m;
    assign a_m     = sel ? a3 : a1;
    assign b_m     = sel ? b3 : b1;
    assign f_m     = sel ? f3 : f1;
    assign cin_m   = sel ? cin3 : cin1;
    assign busy_m  = sel ? busy3 : busy1;
    assign done_m  = sel ? done3 : done1;
    assign pc_m    = sel ? pc3 : pc1;
    assign fc_m    = sel ? fc3 : fc1;
    assign ffv_m   = sel ? ffv3 : ffv1;
    assign ffvec_m = sel ? ffvec3 : ffvec1;

    // Expected tallies: faulty ALU vs fault-free ALU on the bits each op checks
    task automatic compute_expected(input logic cin, output int ep, output int ef,
                                    output logic efv, output logic [9:0] evec);
        logic [7:0] good, got, mask;
        ep = 0; ef = 0; efv = 1'b0; evec = '0;
        for (int i = 0; i < 1024; i++) begin
            good = alu_model(4'(i >> 4), 4'(i), 3'(i >> 8), cin, 0, 0, 0);
            got  = alu_model(4'(i >> 4), 4'(i), 3'(i >> 8), cin, fk, fop, fbit);
            case (i >> 8)
                0:       mask = 8'b1111_1010;
                1:       mask = 8'b1111_0101;
                default: mask = 8'b1111_0000;
            endcase
            if (((good ^ got) & mask) != 8'd0) begin
                ef++;
                if (!efv) begin
                    efv  = 1'b1;
                    evec = 10'(i);
                end
            end else begin
                ep++;
            end
        end
    endtask

    // Runs one sweep; k counts falling edges after the accepting rising edge
    task automatic run_sweep(input logic s, input logic cin, input bit repulse,
                             output int lat, output int busy_low, output logic done_wide,
                             output logic busy_after, output logic cleared,
                             output logic [11:0] vec0);
        int k;
        @(negedge clk);
        sel = s; start = 1'b1; cin_cfg = cin;
        @(negedge clk);
        start = 1'b0; cin_cfg = 1'($urandom);
        cleared = (pc_m == 0) && (fc_m == 0) && !ffv_m && busy_m;
        @(negedge clk);
        vec0 = {f_m, a_m, b_m, cin_m};
        k = 2; lat = -1; busy_low = 0;
        while (k < 8000) begin
            @(negedge clk);
            k++;
            if (done_m) break;
            if (!busy_m) busy_low++;
            if (repulse) start = 1'($urandom_range(0, 1));
        end
        if (done_m) lat = k - 1;
        start = repulse;
        @(negedge clk);
        done_wide = done_m; busy_after = busy_m;
        start = 1'b0;
    endtask

    task automatic test_reset();
        sel = 1'b1;
        @(negedge clk); start = 1'b1; cin_cfg = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (50) @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b0; #1;
        checks++;
        if ({a_m, b_m, f_m, cin_m} !== {4'd0, 4'd0, 3'b111, 1'b0}) begin
            failures++;
            $display("FAIL reset_alu_drive: got %h want %h", {a_m, b_m, f_m, cin_m}, 12'h00e);
        end
        checks++;
        if ({busy_m, done_m} !== 2'b00) begin
            failures++;
            $display("FAIL reset_busy_done: got %b want 00", {busy_m, done_m});
        end
        checks++;
        if ({pc_m, fc_m} !== 22'd0) begin
            failures++;
            $display("FAIL reset_counts: got pass=%0d fail=%0d want 0 0", pc_m, fc_m);
        end
        checks++;
        if ({ffv_m, ffvec_m} !== 11'd0) begin
            failures++;
            $display("FAIL reset_first_fail: got %b/%h want 0/0", ffv_m, ffvec_m);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_clean_sweep();
        int lat, bl, ep, ef;
        logic dw, ba, clr, efv;
        logic [11:0] v0;
        logic [9:0] evec;
        fk = 0;
        compute_expected(1'b0, ep, ef, efv, evec);
        run_sweep(1'b0, 1'b0, 1'b0, lat, bl, dw, ba, clr, v0);
        checks++;
        if (lat != 3072) begin
            failures++;
            $display("FAIL clean_latency: got %0d want 3072", lat);
        end
        checks++;
        if (!clr || v0 !== 12'h000) begin
            failures++;
            $display("FAIL clean_start_state: got cleared=%b vec0=%h want 1/000", clr, v0);
        end
        checks++;
        if ({pc_m, fc_m, ffv_m} !== {11'd1024, 11'd0, 1'b0} || ep != 1024) begin
            failures++;
            $display("FAIL clean_counts: got pass=%0d fail=%0d ffv=%b want 1024 0 0",
                     pc_m, fc_m, ffv_m);
        end
        checks++;
        if (dw !== 1'b0 || ba !== 1'b0 || bl != 0) begin
            failures++;
            $display("FAIL clean_pulse: got done_next=%b busy_after=%b busy_gaps=%0d want 0 0 0",
                     dw, ba, bl);
        end
        repeat (5) @(negedge clk);
        checks++;
        if ({pc_m, f_m, a_m, b_m, busy_m} !== {11'd1024, 3'b111, 4'd0, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL clean_hold: got pass=%0d f=%b a=%h b=%h busy=%b want 1024 111 0 0 0",
                     pc_m, f_m, a_m, b_m, busy_m);
        end
    endtask

    task automatic test_and_stuck();
        int lat, bl, ep, ef;
        logic dw, ba, clr, efv;
        logic [11:0] v0;
        logic [9:0] evec;
        fk = 1; fop = 2; fbit = 0;
        compute_expected(1'b0, ep, ef, efv, evec);
        run_sweep(1'b0, 1'b0, 1'b0, lat, bl, dw, ba, clr, v0);
        checks++;
        if ({pc_m, fc_m} !== {11'd960, 11'd64} || ef != 64) begin
            failures++;
            $display("FAIL and_stuck_counts: got pass=%0d fail=%0d want 960 64", pc_m, fc_m);
        end
        checks++;
        if ({ffv_m, ffvec_m} !== {1'b1, 10'b10_0001_0001}) begin
            failures++;
            $display("FAIL and_stuck_first: got %b/%b want 1/1000010001", ffv_m, ffvec_m);
        end
    endtask

    task automatic test_cout_stuck();
        int lat, bl, ep, ef;
        logic dw, ba, clr, efv;
        logic [11:0] v0;
        logic [9:0] evec;
        fk = 3; fop = 0; fbit = 0;
        compute_expected(1'b1, ep, ef, efv, evec);
        run_sweep(1'b0, 1'b1, 1'b0, lat, bl, dw, ba, clr, v0);
        checks++;
        if ({pc_m, fc_m} !== {11'd888, 11'd136} || ef != 136) begin
            failures++;
            $display("FAIL cout_stuck_counts: got pass=%0d fail=%0d want 888 136", pc_m, fc_m);
        end
        checks++;
        if ({ffv_m, ffvec_m} !== {1'b1, 10'b00_0000_1111} || v0 !== 12'h001) begin
            failures++;
            $display("FAIL cout_stuck_first: got %b/%b vec0=%h want 1/0000001111 001",
                     ffv_m, ffvec_m, v0);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bl, ep, ef;
        logic dw, ba, clr, efv, cin;
        logic [11:0] v0;
        logic [9:0] evec;
        fk = 2; fop = 1; fbit = int'($urandom_range(0, 3));
        cin = 1'($urandom);
        compute_expected(cin, ep, ef, efv, evec);
        run_sweep(1'b1, cin, 1'b1, lat, bl, dw, ba, clr, v0);
        checks++;
        if (lat != 5120 || bl != 0) begin
            failures++;
            $display("FAIL repulse_latency: got %0d gaps=%0d want 5120 0", lat, bl);
        end
        checks++;
        if ({pc_m, fc_m, ffv_m, ffvec_m} !== {11'(ep), 11'(ef), efv, evec}) begin
            failures++;
            $display("FAIL repulse_counts: got %0d/%0d %b/%h want %0d/%0d %b/%h",
                     pc_m, fc_m, ffv_m, ffvec_m, ep, ef, efv, evec);
        end
        checks++;
        if (dw !== 1'b0 || ba !== 1'b0) begin
            failures++;
            $display("FAIL repulse_done_start: got done_next=%b busy_after=%b want 0 0", dw, ba);
        end
    endtask

    task automatic test_random_faults();
        int lat, bl, ep, ef;
        logic dw, ba, clr, efv, cin, s;
        logic [11:0] v0;
        logic [9:0] evec;
        for (int it = 0; it < 4; it++) begin
            fk = int'($urandom_range(0, 4)); fop = int'($urandom_range(0, 3));
            fbit = int'($urandom_range(0, 3));
            cin = 1'($urandom); s = 1'($urandom);
            compute_expected(cin, ep, ef, efv, evec);
            run_sweep(s, cin, 1'b0, lat, bl, dw, ba, clr, v0);
            checks++;
            if (lat != (s ? 5120 : 3072)) begin
                failures++;
                $display("FAIL rand%0d_latency: got %0d want %0d", it, lat, s ? 5120 : 3072);
            end
            checks++;
            if ({pc_m, fc_m, ffv_m, ffvec_m} !== {11'(ep), 11'(ef), efv, evec}) begin
                failures++;
                $display("FAIL rand%0d_counts k=%0d op=%0d bit=%0d: got %0d/%0d %b/%h want %0d/%0d %b/%h",
                         it, fk, fop, fbit, pc_m, fc_m, ffv_m, ffvec_m, ep, ef, efv, evec);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int lat, bl, bad;
        logic dw, ba, clr;
        logic [11:0] v0;
        fk = 0;
        @(negedge clk); sel = 1'b0; start = 1'b1; cin_cfg = 1'b0;
        @(negedge clk); start = 1'b0;
        repeat (1501) @(negedge clk);
        checks++;
        if (pc_m !== 11'd500 || !busy_m) begin
            failures++;
            $display("FAIL midreset_progress: got pass=%0d busy=%b want 500 1", pc_m, busy_m);
        end
        #2 rst_n = 1'b0; #1;
        checks++;
        if ({busy_m, done_m, pc_m, fc_m, ffv_m, f_m} !== {2'b00, 22'd0, 1'b0, 3'b111}) begin
            failures++;
            $display("FAIL midreset_outputs: got busy=%b done=%b pass=%0d fail=%0d f=%b",
                     busy_m, done_m, pc_m, fc_m, f_m);
        end
        @(negedge clk); rst_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy_m || done_m) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL midreset_idle: got %0d active cycles want 0", bad);
        end
        run_sweep(1'b0, 1'b0, 1'b0, lat, bl, dw, ba, clr, v0);
        checks++;
        if (pc_m !== 11'd1024 || fc_m !== 11'd0 || lat != 3072) begin
            failures++;
            $display("FAIL midreset_resweep: got pass=%0d fail=%0d lat=%0d want 1024 0 3072",
                     pc_m, fc_m, lat);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_clean_sweep();
        test_and_stuck();
        test_cout_stuck();
        test_back_to_back();
        test_random_faults();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_test_sequencer.md
ALU_TEST_SEQUENCER -- requirements
Module: alu_test_sequencer

Interface
REQ-001 SETTLE_CYCLES, default 1, number of idle cycles between driving a vector and sampling the result; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to run one full sweep; sampled only in IDLE.
REQ-005 cin_cfg  input  1  carry-in value applied to every vector of a sweep; captured when start is accepted.
REQ-006 alu_a, alu_b  output  4 each  operands driven to the ALU under test.
REQ-007 alu_f  output  3  operation select: 000 add, 001 sub, 010 and, 011 or.
REQ-008 alu_cin  output  1  carry-in driven to the ALU.
REQ-009 alu_z  input  4  ALU result.
REQ-010 alu_cout_add, alu_cout_sub, alu_ovf_add, alu_ovf_sub  input  1 each  ALU flags.
REQ-011 busy  output  1  high while a sweep is in progress.
REQ-012 done  output  1  one-cycle pulse at sweep end.
REQ-013 pass_count, fail_count  output  11 each  vectors passed / failed in the current or last sweep.
REQ-014 first_fail_valid  output  1; first_fail_vec  output  10  {op[1:0], a, b} of the first failing vector.

Function
REQ-015 Sweep covers 1024 vectors, index {op[1:0], a, b}; b increments fastest, then a, then op; alu_f = {1'b0, op}.
REQ-016 FSM states IDLE, DRIVE, SETTLE, CHECK, DONE.
REQ-017 IDLE -> DRIVE when start=1: clear both counters, clear first_fail_valid, index=0, capture cin_cfg.
REQ-018 DRIVE (1 cycle): registered alu_a/alu_b/alu_f/alu_cin updated to current vector; -> SETTLE.
REQ-019 SETTLE: hold outputs exactly SETTLE_CYCLES cycles; -> CHECK.
REQ-020 CHECK (1 cycle): sample ALU outputs, compare with internal model, increment exactly one of pass_count/fail_count; -> DRIVE with index+1, or -> DONE after index 1023 (no index wrap is observed).
REQ-021 DONE (1 cycle): done=1, busy=0 in that cycle; -> IDLE; alu_f returns to 3'b111, alu_a/alu_b/alu_cin to 0.
REQ-022 busy=1 in DRIVE, SETTLE, CHECK; 0 otherwise. Each vector takes SETTLE_CYCLES+2 cycles.
REQ-023 Add model: S=a+b+cin (5-bit); z=S[3:0]; cout=S[4]; ovf=1 iff signed(a)+signed(b)+cin outside -8..7. Checks z, alu_cout_add, alu_ovf_add.
REQ-024 Sub model: z=(a-b-cin) mod 16; cout=1 iff a >= b+cin (unsigned, no borrow); ovf=1 iff signed(a)-signed(b)-cin outside -8..7. Checks z, alu_cout_sub, alu_ovf_sub.
REQ-025 And/Or model: z=a&b / a|b; flags ignored for these ops.
REQ-026 Any x/z on a checked bit counts as mismatch.
REQ-027 On first mismatch of a sweep: first_fail_vec=index, first_fail_valid=1; later mismatches do not overwrite.
REQ-028 start ignored outside IDLE; start asserted during DONE cycle is ignored.
REQ-029 Counters and first_fail_* hold after DONE until next accepted start.

Reset
REQ-030 rst_n=0 immediately forces: state IDLE, alu_a=0, alu_b=0, alu_f=3'b111, alu_cin=0, busy=0, done=0, pass_count=0, fail_count=0, first_fail_valid=0, first_fail_vec=0.
REQ-031 Reset mid-sweep aborts without a done pulse; after release the block waits in IDLE for start.

Verification
REQ-032 Reset: assert rst_n=0 mid-cycle -> all outputs at REQ-030 values before next clk edge.
REQ-033 Correct ALU, cin_cfg=0, SETTLE_CYCLES=1, start accepted at edge N -> done high exactly 3072 cycles later (one cycle), pass_count=1024, fail_count=0, first_fail_valid=0.
REQ-034 ALU with z[0] stuck 0 for and only, cin_cfg=0 -> fail_count=64, pass_count=960, first_fail_vec=10'b10_0001_0001.
REQ-035 ALU with alu_cout_add stuck 0, cin_cfg=1 -> fail_count=136, first_fail_vec=10'b00_0000_1111.
REQ-036 SETTLE_CYCLES=3, start re-pulsed while busy -> single sweep, done exactly 5120 cycles after start, counters unaffected by extra pulses.
REQ-037 rst_n low during vector 500 -> busy=0, counters 0, no done; new start runs a clean full sweep with pass_count=1024.
